// File: rtl/sdram_init_monitor_pkg.sv
// Shared constants for the SDRAM power-up sequence monitor: command nibbles,
// FSM phase encodings, violation codes and the decoded mode-word layout.
package sdram_init_monitor_pkg;

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AUTOREF   = 4'b0001;
  localparam logic [3:0] CMD_MRS       = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_BST       = 4'b0110;

  localparam logic [3:0] MPWR   = 4'd0;
  localparam logic [3:0] MTRP   = 4'd1;
  localparam logic [3:0] MRFC1  = 4'd2;
  localparam logic [3:0] MRFC2  = 4'd3;
  localparam logic [3:0] MTMRD  = 4'd4;
  localparam logic [3:0] MREADY = 4'd5;
  localparam logic [3:0] MERR   = 4'd6;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_PREMATURE = 3'd1;
  localparam logic [2:0] ERR_WRONG_CMD = 3'd2;
  localparam logic [2:0] ERR_TRP       = 3'd3;
  localparam logic [2:0] ERR_TRFC      = 3'd4;
  localparam logic [2:0] ERR_MODE      = 3'd5;
  localparam logic [2:0] ERR_TMRD      = 3'd6;

  typedef struct packed {
    logic [2:0] burstLen;
    logic       burstType;
    logic [2:0] casLat;
  } modeFields_t;

  function automatic int ceilDiv(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/sdram_mode_check.sv
// Splits a mode-register word into its fields and flags whether the
// burst length, CAS latency and reserved bits form a supported mode.
module sdram_mode_check
  import sdram_init_monitor_pkg::*;
(
  input  logic [8:0]  i_mode,
  output logic        o_legal,
  output modeFields_t o_fields
);

  logic w_blOk;
  logic w_clOk;
  logic w_reservedOk;

  assign w_blOk       = i_mode[2:0] inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b111};
  assign w_clOk       = i_mode[6:4] inside {3'b010, 3'b011};
  assign w_reservedOk = (i_mode[8:7] == 2'b00);

  assign o_legal           = w_blOk && w_clOk && w_reservedOk;
  assign o_fields.burstLen  = i_mode[2:0];
  assign o_fields.burstType = i_mode[3];
  assign o_fields.casLat    = i_mode[6:4];

endmodule

// File: rtl/sdram_init_monitor.sv
// Passive checker for the SDRAM power-up sequence: decodes each sampled
// command, enforces ordering and spacing, latches the mode word, flags the first violation.
module sdram_init_monitor
  import sdram_init_monitor_pkg::*;
#(
  parameter int  SDRAMMHZ  = 100,
  parameter int  SDRAMLINE = 2048,
  localparam int AW        = $clog2(SDRAMLINE)
) (
  input  logic          Clk,
  input  logic          Rest,
  input  logic [3:0]    SdramCmd,
  input  logic [AW-1:0] SdramMode,
  output logic          DevReady,
  output logic [2:0]    ModeBurstLen,
  output logic          ModeBurstType,
  output logic [2:0]    ModeCasLat,
  output logic          InitErr,
  output logic [2:0]    ErrCode,
  output logic [3:0]    InitPhase
);

  localparam int NSPRESEC  = ceilDiv(1000, SDRAMMHZ);
  localparam int CYCNUMST  = ceilDiv(200, NSPRESEC);
  localparam int CYCNUMRP  = ceilDiv(20, NSPRESEC);
  localparam int CYCNUMRFC = ceilDiv(70, NSPRESEC);
  localparam int CYCNUMMRD = 2;

  localparam logic [8:0] LIM_ST  = 9'(CYCNUMST);
  localparam logic [8:0] LIM_RP  = 9'(CYCNUMRP);
  localparam logic [8:0] LIM_RFC = 9'(CYCNUMRFC);
  localparam logic [8:0] LIM_MRD = 9'(CYCNUMMRD);

  logic [3:0]    r_state;
  logic [7:0]    r_gap;
  logic          r_devReady;
  logic          r_initErr;
  logic [2:0]    r_errCode;
  modeFields_t   r_mode;

  logic [3:0]    w_nextState;
  logic          w_err;
  logic [2:0]    w_errCode;
  logic          w_loadMode;
  logic          w_isNop;
  logic          w_a10;
  logic [8:0]    w_gap;
  logic [8:0]    w_spacing;
  logic          w_modeLegal;
  modeFields_t   w_modeFields;
  logic [AW-1:0] w_unusedAddr;

  // Deselect (CS_n high) is indistinguishable from NOP for sequencing purposes.
  assign w_isNop      = SdramCmd[3] || (SdramCmd == CMD_NOP);
  assign w_a10        = SdramMode[10];
  assign w_gap        = {1'b0, r_gap};
  assign w_spacing    = w_gap + 9'd1;
  assign w_unusedAddr = SdramMode;

  sdram_mode_check u_modeCheck (
    .i_mode   (SdramMode[8:0]),
    .o_legal  (w_modeLegal),
    .o_fields (w_modeFields)
  );

  always_comb begin
    w_nextState = r_state;
    w_err       = 1'b0;
    w_errCode   = ERR_NONE;
    w_loadMode  = 1'b0;
    case (r_state)
      MPWR: begin
        if (!w_isNop) begin
          if (SdramCmd == CMD_PRECHARGE && w_a10) begin
            if (w_gap >= LIM_ST) w_nextState = MTRP;
            else begin w_err = 1'b1; w_errCode = ERR_PREMATURE; end
          end else begin
            w_err = 1'b1; w_errCode = ERR_WRONG_CMD;
          end
        end
      end
      MTRP: begin
        if (!w_isNop) begin
          if (SdramCmd == CMD_AUTOREF) begin
            if (w_spacing >= LIM_RP) w_nextState = MRFC1;
            else begin w_err = 1'b1; w_errCode = ERR_TRP; end
          end else begin
            w_err = 1'b1; w_errCode = ERR_WRONG_CMD;
          end
        end
      end
      MRFC1: begin
        if (!w_isNop) begin
          if (SdramCmd == CMD_AUTOREF) begin
            if (w_spacing >= LIM_RFC) w_nextState = MRFC2;
            else begin w_err = 1'b1; w_errCode = ERR_TRFC; end
          end else begin
            w_err = 1'b1; w_errCode = ERR_WRONG_CMD;
          end
        end
      end
      // Refresh spacing is judged before mode legality when both are wrong.
      MRFC2: begin
        if (!w_isNop) begin
          if (SdramCmd == CMD_MRS) begin
            if (w_spacing < LIM_RFC) begin
              w_err = 1'b1; w_errCode = ERR_TRFC;
            end else if (!w_modeLegal) begin
              w_err = 1'b1; w_errCode = ERR_MODE;
            end else begin
              w_nextState = MTMRD;
              w_loadMode  = 1'b1;
            end
          end else begin
            w_err = 1'b1; w_errCode = ERR_WRONG_CMD;
          end
        end
      end
      MTMRD: begin
        if (!w_isNop) begin
          w_err = 1'b1; w_errCode = ERR_TMRD;
        end else if (w_spacing >= LIM_MRD) begin
          w_nextState = MREADY;
        end
      end
      MREADY: begin
        if (!w_isNop && SdramCmd == CMD_MRS && w_modeLegal) begin
          w_nextState = MTMRD;
          w_loadMode  = 1'b1;
        end
      end
      MERR:    w_nextState = MERR;
      default: w_nextState = MERR;
    endcase
    if (w_err) w_nextState = MERR;
  end

  // Gap counts NOP edges since the last command and doubles as the tMRD timer.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_state    <= MPWR;
      r_gap      <= 8'd0;
      r_devReady <= 1'b0;
      r_initErr  <= 1'b0;
      r_errCode  <= ERR_NONE;
      r_mode     <= '0;
    end else begin
      r_state    <= w_nextState;
      r_gap      <= w_isNop ? ((r_gap == 8'hFF) ? r_gap : r_gap + 8'd1) : 8'd0;
      r_devReady <= (w_nextState == MREADY);
      if (w_err) begin
        r_initErr <= 1'b1;
        r_errCode <= w_errCode;
      end
      if (w_loadMode) r_mode <= w_modeFields;
    end
  end

  assign DevReady      = r_devReady;
  assign ModeBurstLen  = r_mode.burstLen;
  assign ModeBurstType = r_mode.burstType;
  assign ModeCasLat    = r_mode.casLat;
  assign InitErr       = r_initErr;
  assign ErrCode       = r_errCode;
  assign InitPhase     = r_state;

endmodule
